// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - packs message bytes into 512-bit SHA-256 blocks with standard padding
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  input  logic         byte_last,
  output logic         byte_ready,
  output logic         block_valid,
  output logic [511:0] block_data,
  output logic         block_first,
  output logic         block_last,
  input  logic         block_ready,
  output logic         busy
);

  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_PAD80   = 3'd1;
  localparam logic [2:0] S_PADZERO = 3'd2;
  localparam logic [2:0] S_PADLEN  = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [2:0]       ret_q, ret_d;
  logic [5:0]       off_q, off_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [511:0]     blk_q, blk_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             run_q;
  logic             wr_en;
  logic [7:0]       wr_byte;
  logic [63:0]      len64;

  assign len64       = 64'(len_q);
  assign byte_ready  = run_q && (state_q == S_COLLECT);
  assign block_valid = (state_q == S_EMIT);
  assign block_first = block_valid && first_q;
  assign block_last  = block_valid && last_q;
  assign block_data  = blk_q;
  assign busy        = busy_q;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    off_d   = off_q;
    len_d   = len_q;
    blk_d   = blk_q;
    first_d = first_q;
    last_d  = last_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;
    wr_byte = 8'h00;
    case (state_q)
      S_COLLECT: begin
        if (byte_valid && run_q) begin
          wr_en   = 1'b1;
          wr_byte = byte_data;
          len_d   = len_q + LEN_W'(8);
          busy_d  = 1'b1;
          if (off_q == 6'd63) begin
            state_d = S_EMIT;
            ret_d   = byte_last ? S_PAD80 : S_COLLECT;
          end else if (byte_last) begin
            state_d = S_PAD80;
          end
        end
      end
      S_PAD80: begin
        wr_en   = 1'b1;
        wr_byte = 8'h80;
        if (off_q == 6'd63) begin
          state_d = S_EMIT;
          ret_d   = S_PADZERO;
        end else if (off_q == 6'd55) begin
          state_d = S_PADLEN;
        end else begin
          state_d = S_PADZERO;
        end
      end
      S_PADZERO: begin
        // Going straight to PADLEN after writing offset 55 keeps one byte per clock.
        if (off_q == 6'd56) begin
          state_d = S_PADLEN;
        end else begin
          wr_en = 1'b1;
          if (off_q == 6'd63) begin
            state_d = S_EMIT;
            ret_d   = S_PADZERO;
          end else if (off_q == 6'd55) begin
            state_d = S_PADLEN;
          end
        end
      end
      S_PADLEN: begin
        wr_en   = 1'b1;
        wr_byte = len64[{~off_q[2:0], 3'b000} +: 8];
        if (off_q == 6'd63) begin
          state_d = S_EMIT;
          last_d  = 1'b1;
        end
      end
      S_EMIT: begin
        if (block_ready) begin
          off_d   = 6'd0;
          first_d = 1'b0;
          if (last_q) begin
            len_d   = '0;
            last_d  = 1'b0;
            first_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_COLLECT;
          end else begin
            state_d = ret_q;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
    if (wr_en) begin
      blk_d[{~off_q, 3'b000} +: 8] = wr_byte;
      off_d = off_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_COLLECT;
      ret_q   <= S_COLLECT;
      off_q   <= 6'd0;
      len_q   <= '0;
      blk_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      off_q   <= off_d;
      len_q   <= len_d;
      blk_q   <= blk_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      run_q   <= 1'b1;
    end
  end

endmodule
